// File: rtl/scnn_pe_array.sv
// rtl/scnn_pe_array.sv - SCNN Cartesian-product PE with scatter-accumulate bank
module scnn_pe_array #(
    parameter int F         = 4,
    parameter int I         = 4,
    parameter int DW        = 16,
    parameter int AW        = 32,
    parameter int IDXW      = 8,
    parameter int MAX_NZ_IP = 16,
    parameter int MAX_NZ_WT = 25,
    parameter int ACC_DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   clear_acc,
    input  logic [3:0]             wt_dim,
    input  logic [7:0]             ip_dim,
    input  logic [IDXW-1:0]        num_nz_ips,
    input  logic [IDXW-1:0]        num_nz_wts,
    input  logic signed [DW-1:0]   compressed_inputs  [MAX_NZ_IP],
    input  logic [IDXW-1:0]        comp_indices_ips   [MAX_NZ_IP],
    input  logic signed [DW-1:0]   compressed_weights [MAX_NZ_WT],
    input  logic [IDXW-1:0]        comp_indices_wts   [MAX_NZ_WT],
    input  logic                   relu_en,
    input  logic                   rd_en,
    input  logic [IDXW-1:0]        rd_addr,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic [AW-1:0]          rd_data
);

    localparam int P    = F * I;
    localparam int SW   = AW + $clog2(P + 1);
    localparam int CNTW = IDXW + 1;
    localparam int IPW  = $clog2(MAX_NZ_IP);
    localparam int WPW  = $clog2(MAX_NZ_WT);
    localparam int AAW  = $clog2(ACC_DEPTH);
    localparam int CW   = 2 * IDXW + 8;
    localparam logic signed [CW-1:0] DEPTH_S = CW'(ACC_DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]               state;
    logic                     clear_q;
    logic                     drain_cnt;
    logic [CNTW-1:0]          ic, wc, n_ic, n_wc;
    logic [CNTW-1:0]          act_pos [I];
    logic [CNTW-1:0]          wt_pos  [F];

    logic signed [DW-1:0]     s0_act  [I];
    logic [IDXW-1:0]          s0_aidx [I];
    logic                     s0_avld [I];
    logic signed [DW-1:0]     s0_wt   [F];
    logic [IDXW-1:0]          s0_widx [F];
    logic                     s0_wvld [F];

    logic signed [2*DW-1:0]   mul     [P];
    logic [IDXW:0]            map     [P];
    logic signed [AW-1:0]     s1_prod [P];
    logic [IDXW-1:0]          s1_addr [P];
    logic                     s1_vld  [P];

    logic signed [AW-1:0]     acc     [ACC_DEPTH];
    logic signed [SW-1:0]     acc_sum [ACC_DEPTH];
    logic                     acc_hit [ACC_DEPTH];
    logic                     acc_ovf [ACC_DEPTH];

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);
    assign n_ic = (CNTW'(num_nz_ips) + CNTW'(I - 1)) / CNTW'(I);
    assign n_wc = (CNTW'(num_nz_wts) + CNTW'(F - 1)) / CNTW'(F);

    // Map an activation/weight flat-index pair to {in_range, output address}.
    function automatic logic [IDXW:0] map_addr(input logic [IDXW-1:0] ia, input logic [IDXW-1:0] iw);
        logic [IDXW-1:0]        ipd, wtd;
        logic signed [CW-1:0]   orow, ocol, od, flat;
        ipd  = IDXW'(ip_dim);
        wtd  = IDXW'(wt_dim);
        orow = $signed(CW'(ia / ipd)) - $signed(CW'(iw / wtd));
        ocol = $signed(CW'(ia % ipd)) - $signed(CW'(iw % wtd));
        od   = $signed(CW'(ipd)) - $signed(CW'(wtd)) + CW'(1);
        flat = orow * od + ocol;
        map_addr = {(orow >= CW'(0)) && (orow < od) && (ocol >= CW'(0)) && (ocol < od)
                    && (flat < DEPTH_S), flat[IDXW-1:0]};
    endfunction

    // Operand slot positions for the current activation/weight chunk pair.
    always_comb begin
        for (int i = 0; i < I; i++) act_pos[i] = ic * CNTW'(I) + CNTW'(i);
        for (int f = 0; f < F; f++) wt_pos[f] = wc * CNTW'(F) + CNTW'(f);
    end

    // Control FSM: walk activation chunks (outer) and weight chunks (inner).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            clear_q   <= 1'b0;
            drain_cnt <= 1'b0;
            ic        <= '0;
            wc        <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state   <= S_LOAD;
                    clear_q <= clear_acc;
                    ic      <= '0;
                    wc      <= '0;
                end
                S_LOAD: state <= (n_ic == '0 || n_wc == '0) ? S_DONE : S_RUN;
                S_RUN: begin
                    if (wc == n_wc - CNTW'(1)) begin
                        wc <= '0;
                        if (ic == n_ic - CNTW'(1)) begin
                            state     <= S_DRAIN;
                            drain_cnt <= 1'b0;
                        end else begin
                            ic <= ic + CNTW'(1);
                        end
                    end else begin
                        wc <= wc + CNTW'(1);
                    end
                end
                S_DRAIN: begin
                    drain_cnt <= 1'b1;
                    if (drain_cnt) state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // S1 combinational: products and output coordinates for every lane pair.
    always_comb begin
        for (int f = 0; f < F; f++) begin
            for (int i = 0; i < I; i++) begin
                mul[f*I+i] = s0_act[i] * s0_wt[f];
                map[f*I+i] = map_addr(s0_aidx[i], s0_widx[f]);
            end
        end
    end

    // S0 operand capture with partial-chunk masking, then S1 product registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < I; i++) begin
                s0_act[i] <= '0; s0_aidx[i] <= '0; s0_avld[i] <= 1'b0;
            end
            for (int f = 0; f < F; f++) begin
                s0_wt[f] <= '0; s0_widx[f] <= '0; s0_wvld[f] <= 1'b0;
            end
            for (int p = 0; p < P; p++) begin
                s1_prod[p] <= '0; s1_addr[p] <= '0; s1_vld[p] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < I; i++) begin
                s0_avld[i] <= (state == S_RUN) && (act_pos[i] < CNTW'(num_nz_ips))
                              && (act_pos[i] < CNTW'(MAX_NZ_IP));
                s0_act[i]  <= compressed_inputs[act_pos[i][IPW-1:0]];
                s0_aidx[i] <= comp_indices_ips[act_pos[i][IPW-1:0]];
            end
            for (int f = 0; f < F; f++) begin
                s0_wvld[f] <= (state == S_RUN) && (wt_pos[f] < CNTW'(num_nz_wts))
                              && (wt_pos[f] < CNTW'(MAX_NZ_WT));
                s0_wt[f]   <= compressed_weights[wt_pos[f][WPW-1:0]];
                s0_widx[f] <= comp_indices_wts[wt_pos[f][WPW-1:0]];
            end
            for (int f = 0; f < F; f++) begin
                for (int i = 0; i < I; i++) begin
                    s1_prod[f*I+i] <= AW'(mul[f*I+i]);
                    s1_addr[f*I+i] <= map[f*I+i][IDXW-1:0];
                    s1_vld[f*I+i]  <= s0_avld[i] && s0_wvld[f] && map[f*I+i][IDXW];
                end
            end
        end
    end

    // S2 combinational: fold all same-cycle products per entry into one wide sum.
    always_comb begin
        for (int a = 0; a < ACC_DEPTH; a++) begin
            acc_sum[a] = SW'(acc[a]);
            acc_hit[a] = 1'b0;
            for (int p = 0; p < P; p++) begin
                if (s1_vld[p] && s1_addr[p] == IDXW'(a)) begin
                    acc_sum[a] = acc_sum[a] + SW'(s1_prod[p]);
                    acc_hit[a] = 1'b1;
                end
            end
            acc_ovf[a] = acc_hit[a] && (acc_sum[a] != SW'($signed(acc_sum[a][AW-1:0])));
        end
    end

    // Accumulator bank and sticky overflow: clear in LOAD, wrap-accumulate in S2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < ACC_DEPTH; a++) acc[a] <= '0;
            overflow <= 1'b0;
        end else if (state == S_LOAD && clear_q) begin
            for (int a = 0; a < ACC_DEPTH; a++) acc[a] <= '0;
            overflow <= 1'b0;
        end else begin
            for (int a = 0; a < ACC_DEPTH; a++) begin
                if (acc_hit[a]) acc[a] <= acc_sum[a][AW-1:0];
                if (acc_ovf[a]) overflow <= 1'b1;
            end
        end
    end

    // Registered read port with optional ReLU clamp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            if (rd_addr >= IDXW'(ACC_DEPTH)) rd_data <= '0;
            else if (relu_en && acc[rd_addr[AAW-1:0]][AW-1]) rd_data <= '0;
            else rd_data <= acc[rd_addr[AAW-1:0]];
        end
    end

endmodule
